// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared MFCC datapath constants and the mel filterbank state type.
package mfcc_pkg;

   localparam int MFCC_ADDR_WIDTH   = 12;
   localparam int MFCC_DATA_WIDTH   = 16;
   localparam int MFCC_WEIGHT_WIDTH = 16;
   localparam int MFCC_WADDR_WIDTH  = 10;
   localparam int MFCC_NBIN_WIDTH   = 8;
   localparam int MFCC_FIDX_WIDTH   = 5;
   localparam int MFCC_ACC_WIDTH    = 40;
   localparam int MFCC_OUT_WIDTH    = MFCC_ACC_WIDTH - 16;

   // Shared with the amplitude stage.
   localparam int NUM_BINS    = 257;
   localparam int NUM_FILTERS = 26;

   typedef enum logic [2:0] {
      MEL_IDLE,
      MEL_DESC,
      MEL_LATCH,
      MEL_RD,
      MEL_MAC,
      MEL_WRITE,
      MEL_DONE
   } mel_state_e;

endpackage

// File: rtl/mel_filterbank_ctrl_if.sv
// mel_filterbank_ctrl_if: start/busy/done, descriptor ROM, amplitude RAM,
// weight ROM and mel RAM signals of the mel filterbank controller.
interface mel_filterbank_ctrl_if
   import mfcc_pkg::*;
#(
   parameter int ADDR_WIDTH   = MFCC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MFCC_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = MFCC_WEIGHT_WIDTH,
   parameter int WADDR_WIDTH  = MFCC_WADDR_WIDTH,
   parameter int NBIN_WIDTH   = MFCC_NBIN_WIDTH,
   parameter int FIDX_WIDTH   = MFCC_FIDX_WIDTH,
   parameter int OUT_WIDTH    = MFCC_OUT_WIDTH
) ();

   logic                    mel_start;
   logic [FIDX_WIDTH-1:0]   desc_addr;
   logic [ADDR_WIDTH-1:0]   desc_start_bin;
   logic [NBIN_WIDTH-1:0]   desc_num_bins;
   logic [WADDR_WIDTH-1:0]  desc_w_base;
   logic [ADDR_WIDTH-1:0]   amp_rd_addr;
   logic [DATA_WIDTH-1:0]   amp_rd_data;
   logic [WADDR_WIDTH-1:0]  w_rd_addr;
   logic [WEIGHT_WIDTH-1:0] w_rd_data;
   logic                    mel_wr_en;
   logic [FIDX_WIDTH-1:0]   mel_wr_addr;
   logic [OUT_WIDTH-1:0]    mel_wr_data;
   logic                    mel_busy;
   logic                    mel_done;

   // Controller side.
   modport master (
      input  mel_start, desc_start_bin, desc_num_bins, desc_w_base,
             amp_rd_data, w_rd_data,
      output desc_addr, amp_rd_addr, w_rd_addr,
             mel_wr_en, mel_wr_addr, mel_wr_data, mel_busy, mel_done
   );

   // Sequencer and memory side.
   modport slave (
      output mel_start, desc_start_bin, desc_num_bins, desc_w_base,
             amp_rd_data, w_rd_data,
      input  desc_addr, amp_rd_addr, w_rd_addr,
             mel_wr_en, mel_wr_addr, mel_wr_data, mel_busy, mel_done
   );

endinterface

// File: rtl/mel_mac_unit.sv
// mel_mac_unit: amplitude x weight multiplier with bin-range guard and a
// clearable accumulator; exposes the truncated energy (acc >> 16).
module mel_mac_unit
   import mfcc_pkg::*;
#(
   parameter int ADDR_WIDTH   = MFCC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MFCC_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = MFCC_WEIGHT_WIDTH,
   parameter int ACC_WIDTH    = MFCC_ACC_WIDTH,
   parameter int OUT_WIDTH    = MFCC_OUT_WIDTH,
   parameter int BIN_LIMIT    = NUM_BINS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic [ADDR_WIDTH-1:0]   bin_idx,
   input  logic [DATA_WIDTH-1:0]   amp,
   input  logic [WEIGHT_WIDTH-1:0] weight,
   output logic [OUT_WIDTH-1:0]    energy
);

   localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

   logic [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]  acc_d;
   logic [ACC_WIDTH-1:0]  acc_q;

   // Product of the current bin, forced to zero past the last valid bin.
   always_comb begin
      prod = '0;
      if (bin_idx < ADDR_WIDTH'(BIN_LIMIT)) begin
         prod = {{WEIGHT_WIDTH{1'b0}}, amp} * {{DATA_WIDTH{1'b0}}, weight};
      end
   end

   // Accumulator next value: clear wins over accumulate.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_WIDTH'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign energy = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: rtl/mel_filterbank_ctrl.sv
// mel_filterbank_ctrl: walks the mel filter descriptor table, accumulates
// weighted amplitude bins per filter and writes one energy per filter.
module mel_filterbank_ctrl
   import mfcc_pkg::*;
#(
   parameter int ADDR_WIDTH   = MFCC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MFCC_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = MFCC_WEIGHT_WIDTH,
   parameter int WADDR_WIDTH  = MFCC_WADDR_WIDTH,
   parameter int NBIN_WIDTH   = MFCC_NBIN_WIDTH,
   parameter int NUM_BINS     = mfcc_pkg::NUM_BINS,
   parameter int NUM_FILTERS  = mfcc_pkg::NUM_FILTERS,
   parameter int FIDX_WIDTH   = MFCC_FIDX_WIDTH,
   parameter int ACC_WIDTH    = MFCC_ACC_WIDTH,
   parameter int OUT_WIDTH    = MFCC_OUT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   mel_filterbank_ctrl_if.master bus
);

   localparam logic [FIDX_WIDTH-1:0] FILT_LAST = FIDX_WIDTH'(NUM_FILTERS - 1);
   localparam logic [NBIN_WIDTH-1:0] NB_ONE    = NBIN_WIDTH'(1);

   mel_state_e              state_d, state_q;
   logic [FIDX_WIDTH-1:0]   filt_d, filt_q;
   logic [NBIN_WIDTH-1:0]   k_d, k_q;
   logic [ADDR_WIDTH-1:0]   start_bin_d, start_bin_q;
   logic [NBIN_WIDTH-1:0]   num_bins_d, num_bins_q;
   logic [WADDR_WIDTH-1:0]  w_base_d, w_base_q;
   logic [ADDR_WIDTH-1:0]   amp_addr_d, amp_addr_q;
   logic [WADDR_WIDTH-1:0]  w_addr_d, w_addr_q;
   logic                    wr_en_d, wr_en_q;
   logic                    done_d, done_q;
   logic                    busy_d, busy_q;
   logic [OUT_WIDTH-1:0]    energy;

   // Next-state, counters and registered outputs; the RD addresses are
   // computed on the transition into RD so they are stable for that cycle.
   always_comb begin
      state_d     = state_q;
      filt_d      = filt_q;
      k_d         = k_q;
      start_bin_d = start_bin_q;
      num_bins_d  = num_bins_q;
      w_base_d    = w_base_q;
      amp_addr_d  = amp_addr_q;
      w_addr_d    = w_addr_q;
      wr_en_d     = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         MEL_IDLE: begin
            if (bus.mel_start) begin
               state_d = MEL_DESC;
               filt_d  = '0;
            end
         end
         MEL_DESC: state_d = MEL_LATCH;
         MEL_LATCH: begin
            start_bin_d = bus.desc_start_bin;
            num_bins_d  = bus.desc_num_bins;
            w_base_d    = bus.desc_w_base;
            k_d         = '0;
            if (bus.desc_num_bins == '0) begin
               state_d = MEL_WRITE;
               wr_en_d = 1'b1;
            end else begin
               state_d    = MEL_RD;
               amp_addr_d = bus.desc_start_bin;
               w_addr_d   = bus.desc_w_base;
            end
         end
         MEL_RD: state_d = MEL_MAC;
         MEL_MAC: begin
            k_d = k_q + NB_ONE;
            if (k_q == num_bins_q - NB_ONE) begin
               state_d = MEL_WRITE;
               wr_en_d = 1'b1;
            end else begin
               state_d    = MEL_RD;
               amp_addr_d = start_bin_q + ADDR_WIDTH'(k_d);
               w_addr_d   = w_base_q + WADDR_WIDTH'(k_d);
            end
         end
         MEL_WRITE: begin
            if (filt_q == FILT_LAST) begin
               state_d = MEL_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = MEL_DESC;
               filt_d  = filt_q + FIDX_WIDTH'(1);
            end
         end
         MEL_DONE: state_d = MEL_IDLE;
         default:  state_d = MEL_IDLE;
      endcase
      busy_d = (state_d != MEL_IDLE);
   end

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= MEL_IDLE;
         filt_q      <= '0;
         k_q         <= '0;
         start_bin_q <= '0;
         num_bins_q  <= '0;
         w_base_q    <= '0;
         amp_addr_q  <= '0;
         w_addr_q    <= '0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         filt_q      <= filt_d;
         k_q         <= k_d;
         start_bin_q <= start_bin_d;
         num_bins_q  <= num_bins_d;
         w_base_q    <= w_base_d;
         amp_addr_q  <= amp_addr_d;
         w_addr_q    <= w_addr_d;
         wr_en_q     <= wr_en_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   mel_mac_unit #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH),
      .OUT_WIDTH    (OUT_WIDTH),
      .BIN_LIMIT    (NUM_BINS)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == MEL_LATCH),
      .en      (state_q == MEL_MAC),
      .bin_idx (start_bin_q + ADDR_WIDTH'(k_q)),
      .amp     (bus.amp_rd_data),
      .weight  (bus.w_rd_data),
      .energy  (energy)
   );

   assign bus.desc_addr   = filt_q;
   assign bus.amp_rd_addr = amp_addr_q;
   assign bus.w_rd_addr   = w_addr_q;
   assign bus.mel_wr_en   = wr_en_q;
   assign bus.mel_wr_addr = filt_q;
   assign bus.mel_wr_data = energy;
   assign bus.mel_busy    = busy_q;
   assign bus.mel_done    = done_q;

endmodule

// File: doc/mel_filterbank_ctrl.md
# mel_filterbank_ctrl

Downstream stage of the amplitude block in the MFCC datapath. After the amplitude stage has filled the amplitude RAM with one frame of spectral magnitudes, this block:
- walks a table of triangular mel filters;
- multiplies each covered bin by its filter weight and accumulates the products;
- writes one mel-band energy per filter into the mel RAM for the log/DCT stages.

It is sequenced by a start pulse, mirroring the amplitude stage's enable, and reports busy/done.

## Interface
Parameters:
- ADDR_WIDTH, 12: amplitude RAM address width
- DATA_WIDTH, 16: amplitude sample width, unsigned
- WEIGHT_WIDTH, 16: filter weight width, unsigned Q0.16
- WADDR_WIDTH, 10: weight ROM address width
- NBIN_WIDTH, 8: bins-per-filter count width
- NUM_BINS, 257: valid amplitude bins, addresses 0..NUM_BINS-1
- NUM_FILTERS, 26: mel filters per frame
- FIDX_WIDTH, 5: filter index width
- ACC_WIDTH, 40: accumulator width
- OUT_WIDTH, 24: mel energy width (ACC_WIDTH-16)

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: clock, rising edge
- rst, in, 1: asynchronous active-high reset
- mel_start, in, 1: one-cycle start pulse; ignored while busy
- desc_addr, out, FIDX_WIDTH: filter descriptor ROM address
- desc_start_bin, in, ADDR_WIDTH: first bin of the filter (1-cycle ROM latency)
- desc_num_bins, in, NBIN_WIDTH: number of bins covered
- desc_w_base, in, WADDR_WIDTH: first weight ROM address for the filter
- amp_rd_addr, out, ADDR_WIDTH: amplitude RAM read address (1-cycle latency)
- amp_rd_data, in, DATA_WIDTH: amplitude read data
- w_rd_addr, out, WADDR_WIDTH: weight ROM address (1-cycle latency)
- w_rd_data, in, WEIGHT_WIDTH: weight data
- mel_wr_en, out, 1: mel RAM write strobe
- mel_wr_addr, out, FIDX_WIDTH: filter index being written
- mel_wr_data, out, OUT_WIDTH: mel energy
- mel_busy, out, 1: high from the cycle after an accepted start until DONE exits
- mel_done, out, 1: one-cycle pulse after the last filter is written

## Operation
States and transitions:
- IDLE: mel_start → DESC, with filt←0.
- DESC: drive desc_addr=filt → LATCH.
- LATCH: register start_bin, num_bins and w_base; clear acc and k. If num_bins==0 → WRITE, else → RD.
- RD: amp_rd_addr=start_bin+k, w_rd_addr=w_base+k → MAC.
- MAC:
  - Update: acc += amp_rd_data*w_rd_data (32-bit product, zero-extended).
  - Bin range: if start_bin+k ≥ NUM_BINS, the product is forced to 0 and the read result is ignored.
  - Step: k++. If k==num_bins-1 before the increment → WRITE, else → RD.
- WRITE: mel_wr_en=1, mel_wr_addr=filt, mel_wr_data=acc[ACC_WIDTH-1:16] (truncation, no rounding). If filt==NUM_FILTERS-1 → DONE, else filt++ → DESC.
- DONE: mel_done=1 → IDLE.

Datapath rules:
- No overflow is possible: 255·(2^32−1) < 2^40.
- Address sums wrap modulo their widths; descriptor correctness is the table's responsibility, except for the NUM_BINS guard above.

Boundary conditions:
- mel_start while not in IDLE: ignored, no effect.
- Reset mid-frame: returns to IDLE immediately; no partial write is issued.

## Timing
- Reset values: every output 0, mel_busy=0, state IDLE, acc=0, filt=0, k=0.
- Start: mel_start sampled at edge 0 → DESC in cycle 1, and mel_busy is high from cycle 1.
- Per filter: 2·num_bins+3 cycles (DESC, LATCH, RD/MAC pairs, WRITE).
- mel_wr_en is a single-cycle pulse per filter, with address and data valid in the same cycle.
- Frame latency: Σ(2·num_bins_i+3) cycles from DESC entry to the last WRITE, plus 1 cycle for DONE.
- ROM/RAM addresses are held stable for the whole RD cycle; read data is sampled only in MAC.

## Structure
- Shared package mfcc_pkg:
  - state encoding constants MEL_IDLE..MEL_DONE;
  - default widths;
  - NUM_BINS and NUM_FILTERS, shared with the amplitude stage.
- One sub-module, mel_mac_unit: multiplier, bin-range guard, accumulator with clear/enable.
- FSM and counters live in the top level.

## Test plan
- Reset mid-MAC (rst high at cycle 10) → all outputs 0 next cycle, no mel_wr_en, a new mel_start runs normally.
- Single filter (NUM_FILTERS=1): start_bin=4, num_bins=3, weights 0x8000, amps 100/200/300 → one write, addr 0, data 300, 9 cycles after DESC entry, then mel_done.
- num_bins=0 → WRITE of 0 after 3 cycles, no amplitude reads.
- Range guard: start_bin=255, num_bins=4, NUM_BINS=257, amps 0xFFFF, weights 0xFFFF → only bins 255–256 accumulate; data = (2·0xFFFE0001)>>16 = 0x1FFFC.
- 26 filters of 10 bins, with mel_start pulsed during busy → exactly 26 writes at addrs 0..25, frame latency 26·23 cycles, a single mel_done.
- Max accumulation: num_bins=255, all inputs 0xFFFF → mel_wr_data = (255·0xFFFE0001)>>16, no wrap.
